// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: iterative AES InvSubBytes engine, BYTES_PER_CYCLE S-box lanes per clock.
// Define INV_SUB_BYTES_FWD_EN to add a `fwd` port that selects the forward S-box per block.
module inv_sub_bytes #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic         fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   dbg_state
);
  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high; a
  // producer never waits on ready to raise valid, and holds valid and its data until the transfer.
  localparam int B = BYTES_PER_CYCLE;
  localparam logic [3:0] LAST_IDX = 4'(16 - B);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Each ROM row holds 16 entries, column 0 in the most significant byte.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [127:0] row;
    case (x[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[{~x[3:0], 3'b111} -: 8];
  endfunction

`ifdef INV_SUB_BYTES_FWD_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [127:0] row;
    case (x[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~x[3:0], 3'b111} -: 8];
  endfunction
`endif

  logic [1:0]   state;
  logic [3:0]   idx;
  logic [127:0] work;
  logic [127:0] next_work;
`ifdef INV_SUB_BYTES_FWD_EN
  logic         fwd_q;
`endif

  logic [3:0] pos      [B];
  logic [7:0] lane_out [B];

  for (genvar g = 0; g < B; g++) begin : g_lane
    logic [7:0] lane_in;
    assign pos[g]  = idx + 4'(g);
    assign lane_in = work[{pos[g], 3'b000} +: 8];
`ifdef INV_SUB_BYTES_FWD_EN
    assign lane_out[g] = fwd_q ? fwd_sbox(lane_in) : inv_sbox(lane_in);
`else
    assign lane_out[g] = inv_sbox(lane_in);
`endif
  end

  always_comb begin
    next_work = work;
    for (int g = 0; g < B; g++) begin
      next_work[{pos[g], 3'b000} +: 8] = lane_out[g];
    end
  end

  // idx is held on the last group so it never overflows; accept clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      work  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            idx   <= '0;
            state <= S_RUN;
`ifdef INV_SUB_BYTES_FWD_EN
            fwd_q <= fwd;
`endif
          end
        end
        S_RUN: begin
          work <= next_work;
          if (idx == LAST_IDX) state <= S_DONE;
          else                 idx   <= idx + 4'(B);
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign out_state = work;
  assign dbg_state = state;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: scoreboard bench for inv_sub_bytes; five instances (B = 1,2,4,8,16)
// share stimulus, the B=4 instance is scoreboarded and all five are checked for latency.
module tb_inv_sub_bytes;
  localparam int NL = 5;
  localparam int MAIN = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
`ifdef INV_SUB_BYTES_FWD_EN
  logic         fwd;
`endif

  logic [NL-1:0] ir_all;
  logic [NL-1:0] ov_all;
  logic [NL-1:0] bz_all;
  logic [127:0]  os_all [NL];
  logic [1:0]    ds_all [NL];

  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] out_state;

  int total;
  int bad;
  logic [127:0] exp_q [$];

  for (genvar l = 0; l < NL; l++) begin : g_dut
    inv_sub_bytes #(.BYTES_PER_CYCLE(1 << l)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd       (fwd),
`endif
      .in_valid  (in_valid),
      .in_ready  (ir_all[l]),
      .in_state  (in_state),
      .out_valid (ov_all[l]),
      .out_ready (out_ready),
      .out_state (os_all[l]),
      .busy      (bz_all[l]),
      .dbg_state (ds_all[l])
    );
  end

  assign in_ready  = ir_all[MAIN];
  assign out_valid = ov_all[MAIN];
  assign busy      = bz_all[MAIN];
  assign out_state = os_all[MAIN];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: forward S-box from GF(2^8) arithmetic
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (gmul(a, 8'(i)) == 8'h01) r = 8'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // checking helpers
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops one expected block per output handshake
  task automatic monitor();
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected actual=%h required=<none>", out_state);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_state", out_state, e);
        end
      end
    end
  endtask

  // driver tasks
  task automatic send(input logic [127:0] s, input logic [127:0] e, input string name);
    int n;
    n = 0;
    in_state = s;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout actual=in_ready=0 required=in_ready=1", name);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while (!(&ir_all) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("all_idle", 128'(ir_all), 128'({NL{1'b1}}));
  endtask

  logic [127:0] pat_in;
  logic [127:0] pat_exp;
  int first [NL];

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_state  = '0;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd       = 1'b0;
`endif
    pat_in  = {{12{8'h16}}, 8'h03, 8'h02, 8'h01, 8'h00};
    pat_exp = {{12{8'hff}}, 8'hd5, 8'h6a, 8'h09, 8'h52};
    fork
      monitor();
    join_none

    // reset values
    #1 rst_n = 1'b0;
    #3;
    check("rst_in_ready", 128'(ir_all), 128'({NL{1'b1}}));
    check("rst_out_valid", 128'(ov_all), 128'd0);
    check("rst_busy", 128'(bz_all), 128'd0);
    for (int l = 0; l < NL; l++) begin
      check("rst_out_state", os_all[l], 128'd0);
      check("rst_dbg_state", 128'(ds_all[l]), 128'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all 0x63 -> all 0x00, busy drops after the handshake
    send({16{8'h63}}, 128'd0, "all63");
    wait_drain("all63_drain");
    check1("all63_busy_after", busy, 1'b0);
    check1("all63_in_ready_after", in_ready, 1'b1);

    // directed pattern on every lane count, latency 16/B
    wait_all_idle();
    out_ready = 1'b0;
    for (int l = 0; l < NL; l++) first[l] = 0;
    send(pat_in, pat_exp, "pattern");
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      for (int l = 0; l < NL; l++) begin
        if (first[l] == 0 && ov_all[l]) first[l] = c;
      end
    end
    for (int l = 0; l < NL; l++) begin
      check("lane_latency", 128'(first[l]), 128'(16 >> l));
      check("lane_out_state", os_all[l], pat_exp);
    end
    out_ready = 1'b1;
    wait_drain("pattern_drain");

    // back-pressure: output held 10 cycles, in_valid pulses ignored
    out_ready = 1'b0;
    send({16{8'h00}}, {16{8'h52}}, "bp");
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      check1("bp_out_valid", out_valid, 1'b1);
      check("bp_out_state", out_state, {16{8'h52}});
      check1("bp_in_ready", in_ready, 1'b0);
      in_valid = c[0];
      in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    in_valid  = 1'b1;
    in_state  = {16{8'h63}};
    out_ready = 1'b1;
    @(posedge clk); #1;
    check1("bp_release_busy", busy, 1'b0);
    check1("bp_release_in_ready", in_ready, 1'b1);
    check1("bp_release_out_valid", out_valid, 1'b0);
    exp_q.push_back(128'd0);
    @(posedge clk); #1;
    check1("bp_next_accept_busy", busy, 1'b1);
    in_valid = 1'b0;
    wait_drain("bp_drain");

    // all 256 byte values: forward S-box model, then the DUT must restore them
    for (int k = 0; k < 16; k++) begin
      logic [127:0] s;
      logic [127:0] e;
      for (int j = 0; j < 16; j++) begin
        e[8*j +: 8] = 8'(16 * k + j);
        s[8*j +: 8] = sbox_model(8'(16 * k + j));
      end
      send(s, e, "exhaustive");
    end
    wait_drain("exhaustive_drain");

    // reset in the second RUN cycle, then a fresh block
    send(pat_in, pat_exp, "rst_run");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_state", out_state, 128'd0);
    check1("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(pat_in, pat_exp, "post_rst");
    wait_drain("post_rst_drain");

`ifdef INV_SUB_BYTES_FWD_EN
    // forward mode on one block, inverse mode on the next
    fwd = 1'b1;
    send(128'd0, {16{8'h63}}, "fwd_block");
    fwd = 1'b0;
    send({16{8'h63}}, 128'd0, "inv_after_fwd");
    wait_drain("fwd_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes.md
# inv_sub_bytes

Iterative AES InvSubBytes engine for the decryption datapath. Accepts a 128-bit state over a valid/ready handshake and substitutes each of its 16 bytes through the AES inverse S-box, `BYTES_PER_CYCLE` bytes per clock. Returns the result over a second valid/ready handshake. It is the decrypt-side counterpart of the forward `sbox` lookup and sits between InvShiftRows and AddRoundKey in the inverse round.

## Interface
- `BYTES_PER_CYCLE`, default 4: inverse S-box instances used per cycle. Legal values are 1, 2, 4, 8 and 16.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_state` holds a block to substitute.
- `in_ready` output 1: the block can accept a new block.
- `in_state` input 128: input state. Byte i is `in_state[8i+7:8i]`.
- `out_valid` output 1: `out_state` holds a finished result.
- `out_ready` input 1: the consumer accepts the result.
- `out_state` output 128: result state, using the same byte mapping as `in_state`.
- `busy` output 1: high in RUN and DONE.

## Operation
- Inverse S-box, defined mathematically and identical to the FIPS-197 InvSbox table:
  - t = rotl1(y) ^ rotl3(y) ^ rotl6(y) ^ 0x05 (inverse affine).
  - InvSbox(y) = t^-1 in GF(2^8) mod 0x11B, with 0^-1 = 0.
  - Implemented as a case-statement ROM, one instance per lane.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_state` into the work register, clear byte index `idx` to 0, and go to RUN.
- RUN:
  - Each cycle, bytes idx .. idx+B-1 of the work register are replaced by their InvSbox values (B = `BYTES_PER_CYCLE`).
  - `idx` then advances by B.
  - When the last group is written (idx+B = 16), go to DONE.
  - Lowest byte index is processed first.
- DONE:
  - `out_valid`=1 and `out_state` = work register, both held stable until `out_ready`=1.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready` = (state == IDLE). There is no same-cycle accept in DONE: a new block is taken no earlier than the cycle after the output handshake.
- `in_state` is ignored outside the accept cycle. Changes to it mid-operation have no effect.
- `idx` is 4 bits. It wraps only through the reset-to-0 at accept, never by overflow.

## Timing
- Reset values:
  - state=IDLE, `idx`=0, work register=0.
  - `in_ready`=1, `out_valid`=0, `out_state`=128'h0, `busy`=0.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The partial result is discarded and `out_valid` drops asynchronously.
- Latency: accept at edge E0; `out_valid` rises after edge E0+16/B. Per B this is:
  - B=1: 16 cycles.
  - B=4: 4 cycles.
  - B=16: 1 cycle.
- Minimum block period with `out_ready` tied high is 16/B + 2 cycles.
- Back-pressure: `out_valid` stays high with `out_state` frozen for any number of cycles while `out_ready`=0.
- `out_state` is registered. There is no combinational path from any input to any output, except `rst_n`.

## Configuration
- Macro: `INV_SUB_BYTES_FWD_EN`.
- Defined:
  - Adds port `fwd` (input, 1 bit), sampled into a mode flop on the accept cycle.
  - `fwd`=1 applies the forward AES S-box to every byte (S(x) = affine(x^-1), giving 0x00→0x63).
  - `fwd`=0 applies InvSbox.
  - The mode flop resets to 0.
  - One block can then serve both the encrypt and decrypt paths.
- Undefined: no `fwd` port, no mode flop, and InvSbox only.

## Test plan
- Reset, then a block of all bytes 0x63 with B=4 → after 4 cycles `out_state` is all 0x00 and `busy` drops after the handshake.
- `in_state` bytes 0..3 = 0x00,0x01,0x02,0x03, rest 0x16 → bytes 0..3 = 0x52,0x09,0x6a,0xd5 and the rest 0xff. Run for B=1, 2, 4, 8, 16 with latency 16/B.
- Exhaustive: all 256 byte values, 16 per block, passed through forward `sbox` and then this block → each output equals the original byte.
- `out_ready` held low 10 cycles in DONE → `out_valid` stays 1, `out_state` stays stable, `in_ready`=0 and `in_valid` pulses are ignored. On release, a new accept occurs no earlier than the next cycle.
- Drive `rst_n` low in the second RUN cycle → all outputs return to their reset values at once. A fresh block after release completes correctly.
- With `INV_SUB_BYTES_FWD_EN` defined, `fwd`=1 on a block of all 0x00 → all 0x63. The next block uses `fwd`=0 on all 0x63 → all 0x00.
